dtcm_ctrl: RTL and testbench

Load/store front-end for the data TCM. It accepts byte, half-word and word requests from the LSU over a valid/ready channel and drives the single-port `sim_ram` (DTCM instance, 32-bit, 4-lane byte mask, 1-cycle registered read). It returns aligned, sign- or zero-extended load data and write acknowledges on a valid/ready response channel. With `rsp_ready` held high it sustains one request per cycle.

---
 rtl/dtcm_ctrl_if.sv | 27 ++
 rtl/dtcm_ctrl.sv | 128 ++++++++++++
 tb/tb_dtcm_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/dtcm_ctrl_if.sv
// LSU-side request/response channel for the data TCM front-end.
// The controller takes the slave modport; the load/store unit takes the master modport.
interface dtcm_ctrl_if #(
    parameter int unsigned AW = 32
) ();
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          req_wr;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    modport master (
        output req_valid, req_addr, req_wr, req_size, req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wr, req_size, req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dtcm_ctrl.sv
// Load/store front-end for the single-port data TCM (1-cycle registered read).
// Define DTCM_MISALIGN_CHK_EN to reject misaligned half/word accesses instead of aligning them.
module dtcm_ctrl #(
    parameter int unsigned DP  = 512,
    parameter int unsigned AW  = 32,
    parameter int unsigned RAW = $clog2(DP)
) (
    input  logic           clk,
    input  logic           rst,
    dtcm_ctrl_if.slave     bus,
    output logic [RAW-1:0] ram_addr,
    output logic           ram_we,
    output logic [3:0]     ram_wem,
    output logic [31:0]    ram_din,
    input  logic [31:0]    ram_dout
);

    typedef enum logic [0:0] {StIdle, StRsp} state_e;

    state_e         state_q;
    logic           err_q;
    logic [1:0]     off_q;
    logic [1:0]     size_q;
    logic           unsigned_q;
    logic           is_load_q;
    logic [RAW-1:0] hold_addr_q;

    logic           req_ready;
    logic           acc;
    logic           err;
    logic           misalign;
    logic [AW-3:0]  idx;
    logic [1:0]     off;
    logic [1:0]     off_eff;
    logic [31:0]    shifted;

    assign idx = bus.req_addr[AW-1:2];
    assign off = bus.req_addr[1:0];

    always_comb begin
        req_ready = (state_q == StIdle) | bus.rsp_ready;
        acc       = bus.req_valid & req_ready;
`ifdef DTCM_MISALIGN_CHK_EN
        misalign = ((bus.req_size == 2'b01) & off[0]) |
                   ((bus.req_size == 2'b10) & (off != 2'b00));
`else
        misalign = 1'b0;
`endif
        err = (idx >= (AW-2)'(DP)) | (bus.req_size == 2'b11) | misalign;
        // Without the check, halves and words are silently aligned down.
        case (bus.req_size)
            2'b01:   off_eff = {off[1], 1'b0};
            2'b10:   off_eff = 2'b00;
            default: off_eff = off;
        endcase
    end

    // RAM side: only a non-error store writes; otherwise the read address is held.
    always_comb begin
        ram_we   = 1'b0;
        ram_wem  = 4'b0000;
        ram_din  = 32'h0;
        ram_addr = hold_addr_q;
        if (acc && !err) begin
            ram_addr = idx[RAW-1:0];
            if (bus.req_wr) begin
                ram_we = 1'b1;
                case (bus.req_size)
                    2'b00: begin
                        ram_wem = 4'b0001 << off_eff;
                        ram_din = {4{bus.req_wdata[7:0]}};
                    end
                    2'b01: begin
                        ram_wem = 4'b0011 << off_eff;
                        ram_din = {2{bus.req_wdata[15:0]}};
                    end
                    default: begin
                        ram_wem = 4'b1111;
                        ram_din = bus.req_wdata;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            err_q       <= 1'b0;
            off_q       <= 2'b00;
            size_q      <= 2'b00;
            unsigned_q  <= 1'b0;
            is_load_q   <= 1'b0;
            hold_addr_q <= '0;
        end else begin
            if (acc) begin
                state_q    <= StRsp;
                err_q      <= err;
                off_q      <= off_eff;
                size_q     <= bus.req_size;
                unsigned_q <= bus.req_unsigned;
                is_load_q  <= ~bus.req_wr;
                if (!bus.req_wr && !err) begin
                    hold_addr_q <= idx[RAW-1:0];
                end
            end else if (state_q == StRsp && bus.rsp_ready) begin
                state_q <= StIdle;
            end
        end
    end

    assign shifted = ram_dout >> {off_q, 3'b000};

    always_comb begin
        bus.req_ready = req_ready;
        bus.rsp_valid = (state_q == StRsp);
        bus.rsp_err   = bus.rsp_valid & err_q;
        bus.rsp_rdata = 32'h0;
        if (bus.rsp_valid && is_load_q && !err_q) begin
            case (size_q)
                2'b00:   bus.rsp_rdata = {{24{~unsigned_q & shifted[7]}}, shifted[7:0]};
                2'b01:   bus.rsp_rdata = {{16{~unsigned_q & shifted[15]}}, shifted[15:0]};
                default: bus.rsp_rdata = shifted;
            endcase
        end
    end

endmodule

// File: tb/tb_dtcm_ctrl.sv
// Scoreboard bench for dtcm_ctrl with a behavioural single-port RAM behind it.
module tb_dtcm_ctrl;
    localparam int unsigned DP  = 512;
    localparam int unsigned AW  = 32;
    localparam int unsigned RAW = $clog2(DP);

    logic           clk;
    logic           rst;
    logic [RAW-1:0] ram_addr;
    logic           ram_we;
    logic [3:0]     ram_wem;
    logic [31:0]    ram_din;
    logic [31:0]    ram_dout;
    logic [31:0]    mem [DP];

    dtcm_ctrl_if #(.AW(AW)) bus ();

    dtcm_ctrl #(.DP(DP), .AW(AW), .RAW(RAW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_wem  (ram_wem),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read register only loads when not writing.
    always @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_wem[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
            end
        end else begin
            ram_dout <= mem[ram_addr];
        end
    end

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (q.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
            end
        end
    end

    task automatic send(input logic [31:0] addr, input logic wr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input logic [3:0] exp_wem);
        int n = 0;
        bus.req_valid    = 1'b1;
        bus.req_addr     = addr;
        bus.req_wr       = wr;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_wdata    = wdata;
        q.push_back('{rdata: exp_rdata, err: exp_err});
        @(negedge clk);
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            chk("req_accept_timeout", 32'd0, 32'd1);
        end else begin
            chk("ram_wem", {28'd0, ram_wem}, {28'd0, exp_wem});
            if (exp_err) chk("err_no_we", {31'd0, ram_we}, 32'd0);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    initial begin
        int t0;
        int n;
        for (int i = 0; i < int'(DP); i++) mem[i] = 32'h0;
        ram_dout         = 32'h0;
        rst              = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_addr     = '0;
        bus.req_wr       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_wdata    = 32'h0;
        bus.rsp_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_ram_din", ram_din, 32'd0);
        @(posedge clk);
        #1;

        send(32'h10, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 4'b1111);
        send(32'h10, 1'b0, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 4'b0000);
        send(32'h13, 1'b1, 2'b00, 1'b0, 32'h5A, 32'h0, 1'b0, 4'b1000);
        send(32'h13, 1'b0, 2'b00, 1'b1, 32'h0, 32'h0000005A, 1'b0, 4'b0000);
        send(32'h11, 1'b1, 2'b00, 1'b0, 32'h80, 32'h0, 1'b0, 4'b0010);
        send(32'h11, 1'b0, 2'b00, 1'b0, 32'h0, 32'hFFFFFF80, 1'b0, 4'b0000);
        send(32'h22, 1'b1, 2'b01, 1'b0, 32'h8001, 32'h0, 1'b0, 4'b1100);
        send(32'h22, 1'b0, 2'b01, 1'b0, 32'h0, 32'hFFFF8001, 1'b0, 4'b0000);
        send(32'h22, 1'b0, 2'b01, 1'b1, 32'h0, 32'h00008001, 1'b0, 4'b0000);
        send(32'h10, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 4'b1111);

        // Backpressure: the load response must hold while rsp_ready is low.
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        send(32'h10, 1'b0, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 4'b0000);
        repeat (5) begin
            @(negedge clk);
            chk("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
            chk("bp_rdata", bus.rsp_rdata, 32'hDEADBEEF);
            chk("bp_ram_addr", 32'(ram_addr), 32'd4);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;

        t0 = cyc;
        send(32'h20, 1'b0, 2'b10, 1'b0, 32'h0, 32'h80010000, 1'b0, 4'b0000);
        send(32'h24, 1'b1, 2'b10, 1'b0, 32'h12345678, 32'h0, 1'b0, 4'b1111);
        send(32'h24, 1'b0, 2'b10, 1'b0, 32'h0, 32'h12345678, 1'b0, 4'b0000);
        chk("b2b_cycles", 32'(cyc - t0), 32'd3);

        send(32'(4 * DP), 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 4'b0000);
        send(32'(4 * DP), 1'b1, 2'b10, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 4'b0000);
        send(32'h10, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 4'b0000);
        send(32'h10, 1'b1, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 4'b0000);
`ifdef DTCM_MISALIGN_CHK_EN
        send(32'h12, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 4'b0000);
`else
        send(32'h12, 1'b0, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 4'b0000);
`endif
        send(32'h10, 1'b0, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 4'b0000);

        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
